cic_interp: RTL
===============

CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 Parameter IN_W, default 20, input sample width (two's complement).
REQ-002 Parameter OUT_W, default 20, output sample width (two's complement).
REQ-003 Parameter RATIO, default 50, interpolation ratio (2..256).
REQ-004 Parameter STAGES, default 3, comb/integrator stage count (1..5).
REQ-005 Parameter OUT_SHIFT, default 11, right-shift applied before rounding to OUT_W.
REQ-006 Port clock, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port v_in, input, IN_W, low-rate input sample.
REQ-009 Port in_valid, input, 1, v_in is valid.
REQ-010 Port in_ready, output, 1, block accepts a sample on this edge.
REQ-011 Port interp_o, output, OUT_W, high-rate output sample, updated every cycle.
REQ-012 Port lo_o, output, 2, LO code: 2'b00 zero, 2'b01 +1, 2'b10 -1.
REQ-013 Port underrun, output, 1, sticky: in_ready slot passed without in_valid.

Function
REQ-014 Phase counter: counts 0..RATIO-1, wraps to 0; in_ready = (phase == 0) and not reset.
REQ-015 Accept edge: in_ready & in_valid at a rising edge; v_in is sign-extended to ACC_W = IN_W + STAGES*clog2(RATIO).
REQ-016 Comb chain (STAGES differences, each of delay 1 low-rate sample) advances only on accept edges or underrun slots; it holds otherwise.
REQ-017 Zero-stuffing: the integrator input equals the comb output for the one cycle after an accept edge and 0 on all other cycles.
REQ-018 Integrators: STAGES pipelined ACC_W accumulators, advancing every cycle, wrapping modulo 2^ACC_W (no saturation internally).
REQ-019 Output: (last integrator + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1], registered.
REQ-020 Latency: an impulse accepted at edge t first affects interp_o after edge t+STAGES+1.
REQ-021 DC gain: RATIO^(STAGES-1) / 2^OUT_SHIFT.
REQ-022 Underrun slot (in_ready=1, in_valid=0): a zero is fed to the comb chain as if accepted, and underrun is set; it stays set until reset.
REQ-023 in_valid while in_ready=0: ignored; the producer holds v_in/in_valid until in_ready.

Reset
REQ-024 Reset forces phase, comb delays, integrators, interp_o, the LO counter and underrun to 0, and in_ready to 0.
REQ-025 Reset asserted mid-operation discards all in-flight state; the first accept opportunity is the first edge after reset deasserts.

Configuration
REQ-026 Macro CIC_MIX_EN defined: 2-bit LO counter runs each cycle from 0; lo_o sequence is 01,00,10,00 repeating; interp_o = filtered value x {+1,0,-1,0}; negating the minimum value saturates to the maximum.
REQ-027 Macro CIC_MIX_EN undefined: no mixing; interp_o is the filtered value; lo_o is tied to 2'b01.

Structure
REQ-028 Package ds_pkg holds: a clog2 function, default parameter constants, and LO code constants (LO_ZERO, LO_POS, LO_NEG).
REQ-029 One sub-module, cic_integrator (single pipelined wrapping accumulator), instantiated STAGES times via generate.

Verification
REQ-030 Impulse: v_in=1 once, then zeros, defaults, CIC_MIX_EN off -> first non-zero interp_o at accept+4 cycles; response is symmetric and sums to 2500/2048 ± rounding.
REQ-031 DC: v_in=1000 every slot -> interp_o settles to 1221 within 3*RATIO cycles and stays constant.
REQ-032 Saturation: v_in=524287 continuously -> interp_o=524287, no wrap glitch.
REQ-033 Underrun: in_valid held low for one slot -> underrun=1 from that edge until reset; output dips consistent with a zero sample.
REQ-034 Reset mid-stream: reset high for 1 cycle at phase 17 -> all outputs 0 next cycle; in_ready=1 on the first edge after release.
REQ-035 CIC_MIX_EN defined, DC 1000 settled -> interp_o repeats 1221,0,-1221,0 in step with lo_o 01,00,10,00.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared constants and helpers for the CIC interpolator slice.
package ds_pkg;

  localparam int IN_W_DEF      = 20;
  localparam int OUT_W_DEF     = 20;
  localparam int RATIO_DEF     = 50;
  localparam int STAGES_DEF    = 3;
  localparam int OUT_SHIFT_DEF = 11;

  localparam logic [1:0] LO_ZERO = 2'b00;
  localparam logic [1:0] LO_POS  = 2'b01;
  localparam logic [1:0] LO_NEG  = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// One wrapping accumulator stage of the CIC integrator cascade.
module cic_integrator #(
  parameter int W = 38
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else       q <= q + d;
  end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator: low-rate comb chain, zero-stuffing, high-rate integrators,
// rounded/saturated output. Optional LO mixer enabled by macro CIC_MIX_EN.
module cic_interp
  import ds_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int RATIO     = RATIO_DEF,
  parameter int STAGES    = STAGES_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  v_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] interp_o,
  output logic [1:0]       lo_o,
  output logic             underrun
);

  localparam int ACC_W = IN_W + STAGES * clog2(RATIO);
  localparam int PH_W  = clog2(RATIO);
  localparam int RND_W = ACC_W + 1;

  localparam logic signed [RND_W-1:0] HALF    = RND_W'((2 ** OUT_SHIFT) / 2);
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [PH_W-1:0] phase;
  logic            slot;

  assign slot     = (phase == '0) && !reset;
  assign in_ready = slot;

  // A missed slot still clocks the combs, with a zero sample
  logic [ACC_W-1:0] x;
  assign x = in_valid ? {{(ACC_W-IN_W){v_in[IN_W-1]}}, v_in} : '0;

  logic [STAGES:0][ACC_W-1:0]   comb_c;
  logic [STAGES-1:0][ACC_W-1:0] comb_dly;
  logic [ACC_W-1:0]             comb_out;
  logic                         stuff_vld;

  always_comb begin
    comb_c    = '0;
    comb_c[0] = x;
    for (int k = 0; k < STAGES; k++)
      comb_c[k+1] = comb_c[k] - comb_dly[k];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= '0;
      comb_dly  <= '0;
      comb_out  <= '0;
      stuff_vld <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      phase     <= (phase == PH_W'(RATIO - 1)) ? '0 : phase + PH_W'(1);
      stuff_vld <= slot;
      if (slot) begin
        for (int k = 0; k < STAGES; k++)
          comb_dly[k] <= comb_c[k];
        comb_out <= comb_c[STAGES];
        if (!in_valid) underrun <= 1'b1;
      end
    end
  end

  // Comb result is presented for exactly one high-rate cycle per slot
  logic [STAGES:0][ACC_W-1:0] integ;
  assign integ[0] = stuff_vld ? comb_out : '0;

  for (genvar g = 0; g < STAGES; g++) begin : g_int
    cic_integrator #(.W(ACC_W)) u_int (
      .clock (clock),
      .reset (reset),
      .d     (integ[g]),
      .q     (integ[g+1])
    );
  end

  // One guard bit keeps the rounding add from wrapping
  logic signed [RND_W-1:0] rnd_sum;
  logic signed [RND_W-1:0] rnd;
  logic signed [OUT_W-1:0] filt;

  assign rnd_sum = $signed({integ[STAGES][ACC_W-1], integ[STAGES]}) + HALF;
  assign rnd     = rnd_sum >>> OUT_SHIFT;

  always_comb begin
    filt = rnd[OUT_W-1:0];
    if (rnd > SAT_MAX)      filt = SAT_MAX[OUT_W-1:0];
    else if (rnd < SAT_MIN) filt = SAT_MIN[OUT_W-1:0];
  end

`ifdef CIC_MIX_EN
  logic [1:0]              lo_cnt;
  logic [1:0]              lo_code;
  logic signed [OUT_W-1:0] mixed;

  always_comb begin
    mixed   = '0;
    lo_code = LO_ZERO;
    case (lo_cnt)
      2'd0: begin
        mixed   = filt;
        lo_code = LO_POS;
      end
      2'd2: begin
        // -min is not representable; clamp to max instead
        mixed   = (filt == SAT_MIN[OUT_W-1:0]) ? SAT_MAX[OUT_W-1:0] : -filt;
        lo_code = LO_NEG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lo_cnt   <= '0;
      lo_o     <= LO_ZERO;
      interp_o <= '0;
    end else begin
      lo_cnt   <= lo_cnt + 2'd1;
      lo_o     <= lo_code;
      interp_o <= mixed;
    end
  end
`else
  assign lo_o = LO_POS;

  always_ff @(posedge clock) begin
    if (reset) interp_o <= '0;
    else       interp_o <= filt;
  end
`endif

endmodule
